alu_uart_interface: RTL and testbench

- Sequencer between the UART receiver/transmitter pair and the ALU.
- Receives three bytes in order (first operator, second operator, opcode) through the RX done/data handshake, drives them to the ALU, and captures the ALU result.
- Hands the result to the UART transmitter with a start pulse, then waits for TX completion before accepting the next frame.
- Replaces the button/switch operand latching on the UART-based build.

---
 rtl/alu_uart_interface.sv | 92 +++++++++
 tb/tb_alu_uart_interface.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// Frame sequencer between the UART RX/TX pair and the ALU: collects A, B and opcode
// bytes, captures the ALU result one cycle later and hands it to the transmitter.
module alu_uart_interface #(
  parameter int NB_DATA_BUS = 8,
  parameter int NB_OPCODE   = 6,
  parameter int NB_DBG_LED  = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_DATA_BUS-1:0] i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_tx_done,
  input  logic [NB_DATA_BUS-1:0] i_alu_result,
  output logic [NB_DATA_BUS-1:0] o_first_operator,
  output logic [NB_DATA_BUS-1:0] o_second_operator,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [NB_DATA_BUS-1:0] o_tx_data,
  output logic                   o_tx_start,
  output logic [NB_DBG_LED-1:0]  o_led_dbg
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'b001,
    WAIT_B  = 3'b010,
    WAIT_OP = 3'b011,
    CALC    = 3'b100,
    WAIT_TX = 3'b101
  } state_e;

  state_e                 state_q;
  logic [NB_DATA_BUS-1:0] first_q;
  logic [NB_DATA_BUS-1:0] second_q;
  logic [NB_OPCODE-1:0]   opcode_q;
  logic [NB_DATA_BUS-1:0] tx_data_q;
  logic                   tx_start_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      first_q    <= '0;
      second_q   <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (i_rx_done) begin
            first_q <= i_rx_data;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_done) begin
            second_q <= i_rx_data;
            state_q  <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            opcode_q <= i_rx_data[NB_OPCODE-1:0];
            state_q  <= CALC;
          end
        end
        CALC: begin
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_TX;
        end
        WAIT_TX: begin
          tx_start_q <= 1'b0;
          // a tx_done coinciding with our own start pulse belongs to no frame of ours
          if (i_tx_done && !tx_start_q) begin
            state_q <= WAIT_A;
          end
        end
        default: begin
          state_q    <= WAIT_A;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_first_operator  = first_q;
  assign o_second_operator = second_q;
  assign o_opcode          = opcode_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_start        = tx_start_q;
  assign o_led_dbg         = NB_DBG_LED'(state_q);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Randomized scoreboard bench for alu_uart_interface with a behavioural ALU and frame model.
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_res;
  logic [7:0] first_op, second_op, tx_data;
  logic [5:0] opcode;
  logic       tx_start;
  logic [2:0] led;

  alu_uart_interface #(.NB_DATA_BUS(8), .NB_OPCODE(6), .NB_DBG_LED(3)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_result(alu_res),
    .o_first_operator(first_op), .o_second_operator(second_op), .o_opcode(opcode),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_led_dbg(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         k;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      6'b100111: return ~(a | b);
      default:   return 8'h00;
    endcase
  endfunction

  assign alu_res = alu_ref(first_op, second_op, opcode);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, "_first"}, 32'(first_op), 32'h0);
    chk({tag, "_second"}, 32'(second_op), 32'h0);
    chk({tag, "_opcode"}, 32'(opcode), 32'h0);
    chk({tag, "_txdata"}, 32'(tx_data), 32'h0);
    chk({tag, "_txstart"}, 32'(tx_start), 32'h0);
    chk({tag, "_led"}, 32'(led), 32'h1);
  endtask

  // Monitor: every new start pulse is matched against the oldest expected frame.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (prev_start) begin
        chk("start_pulse_len", 32'(tx_start), 32'h0);
        chk("led_wait_tx", 32'(led), 32'h5);
      end
      if (tx_start && !prev_start) begin
        n_starts++;
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start: got start pulse, required none (tx_data 0x%0h)", tx_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_tx_data", 32'(tx_data), 32'(e.res));
          chk("sb_first", 32'(first_op), 32'(e.a));
          chk("sb_second", 32'(second_op), 32'(e.b));
          chk("sb_opcode", 32'(opcode), 32'(e.op));
          chk("sb_latency", 32'(cyc), 32'(e.k + 1));
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic send_byte(logic [7:0] b, int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_frame(logic [7:0] a, logic [7:0] b, logic [7:0] op, int maxgap);
    exp_t e;
    send_byte(a, int'($urandom_range(0, maxgap)));
    send_byte(b, int'($urandom_range(0, maxgap)));
    send_byte(op, int'($urandom_range(0, maxgap)));
    e.a   = a;
    e.b   = b;
    e.op  = op[5:0];
    e.res = alu_ref(a, b, op[5:0]);
    e.k   = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_start();
    int t = 0;
    while (!tx_start && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!tx_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_timeout: no start pulse within 30 cycles, led 0x%0h", led);
    end
  endtask

  task automatic finish_tx(int delay);
    repeat (delay) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("led_back_to_wait_a", 32'(led), 32'h1);
  endtask

  logic [5:0] op_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100110, 6'b000011, 6'b000010, 6'b100111};

  initial begin
    int s0;
    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_cleared("por");
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-frame discards A
    send_byte(8'h5A, 0);
    chk("midframe_led", 32'(led), 32'h2);
    chk("midframe_first", 32'(first_op), 32'h5A);
    #2 rst = 1'b1;
    #1 chk_cleared("rst_wait_b");
    @(negedge clk);
    rst = 1'b0;

    send_frame(8'h05, 8'h03, 8'h20, 0);
    wait_start();
    chk("add_result", 32'(tx_data), 32'h08);
    chk("add_first", 32'(first_op), 32'h05);
    finish_tx(3);

    // Upper opcode bits dropped, then a byte during WAIT_TX is ignored
    send_frame(8'h0F, 8'h01, 8'hE2, 1);
    wait_start();
    chk("trunc_opcode", 32'(opcode), 32'h22);
    chk("sub_result", 32'(tx_data), 32'h0E);
    send_byte(8'hAA, 0);
    chk("rx_in_tx_led", 32'(led), 32'h5);
    chk("rx_in_tx_first", 32'(first_op), 32'h0F);
    finish_tx(1);

    send_frame(8'h10, 8'h20, 8'h25, 1);
    wait_start();
    chk("or_result", 32'(tx_data), 32'h30);
    chk("or_first", 32'(first_op), 32'h10);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("txdone_with_start_ignored", 32'(led), 32'h5);
    repeat (2) @(negedge clk);
    chk("still_wait_tx", 32'(led), 32'h5);
    finish_tx(1);

    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("txdone_in_wait_a_ignored", 32'(led), 32'h1);

    // Back-to-back frames
    s0 = n_starts;
    send_frame(8'h33, 8'h0C, 8'h26, 0);
    wait_start();
    finish_tx(1);
    send_frame(8'h81, 8'h02, 8'h03, 0);
    wait_start();
    finish_tx(2);
    chk("b2b_starts", 32'(n_starts - s0), 32'h2);

    // Reset during WAIT_TX
    send_frame(8'hC3, 8'h3C, 8'h24, 0);
    wait_start();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_cleared("rst_wait_tx");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] up;
      logic [7:0] opb;
      up  = 2'($urandom_range(0, 3));
      opb = {up, op_tab[$urandom_range(0, 7)]};
      send_frame(8'($urandom), 8'($urandom), opb, 2);
      wait_start();
      if ($urandom_range(0, 2) == 0) begin
        send_byte(8'($urandom), 0);
        chk("rand_rx_ignored", 32'(led), 32'h5);
      end
      finish_tx(int'($urandom_range(1, 4)));
    end

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
